// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register and
// stalls decode when an instruction reads a register with an outstanding write,
// or would overflow that register's pending-write counter.
module reg_scoreboard #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [3:0]      issue_dst,
    input  logic [3:0]      src1,
    input  logic            src1_used,
    input  logic [3:0]      src2,
    input  logic            src2_used,
    input  logic            wb_valid,
    input  logic [3:0]      wb_dst,
    input  logic            kill_valid,
    input  logic [3:0]      kill_dst,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] pending,
    output logic            err
);

    localparam int unsigned IdW  = 4;
    localparam int unsigned SumW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cntQ [NREG];
    logic [CNT_W-1:0] cntD [NREG];
    logic [NREG-1:0]  pendingD;
    logic             underflow;

    logic hazard1;
    logic hazard2;
    logic structural;
    logic dstRetiring;

    // Returns {underflow, next count}; the arithmetic is one bit wider so that
    // an issue plus a retire never wraps, and an over-retire clamps to zero.
    function automatic logic [SumW-1:0] updCount(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             wbHit,
        input logic             killHit
    );
        logic [SumW-1:0] sum;
        logic [SumW-1:0] dec;
        sum = SumW'(cur) + SumW'(inc);
        dec = SumW'(wbHit) + SumW'(killHit);
        if (dec > sum) begin
            return {1'b1, {CNT_W{1'b0}}};
        end
        return {1'b0, CNT_W'(sum - dec)};
    endfunction

    // Read-after-write hazards; a last pending write retiring this cycle is
    // forwarded by the register file, so it does not stall.
    always_comb begin
        hazard1 = src1_used && (src1 != '0) && (cntQ[src1] != '0) &&
                  !(wb_valid && (wb_dst == src1) && (cntQ[src1] == CntOne));
        hazard2 = src2_used && (src2 != '0) && (cntQ[src2] != '0) &&
                  !(wb_valid && (wb_dst == src2) && (cntQ[src2] == CntOne));
    end

    // Counter-full stall, lifted when the same register frees a slot this cycle.
    always_comb begin
        dstRetiring = (wb_valid && (wb_dst == issue_dst)) ||
                      (kill_valid && (kill_dst == issue_dst));
        structural  = issue_wr && (issue_dst != '0) && (cntQ[issue_dst] == CntMax) &&
                      !dstRetiring;
    end

    // Decode handshake.
    always_comb begin
        stall      = issue_valid && (hazard1 || hazard2 || structural);
        issue_fire = issue_valid && !stall;
    end

    // Next counter values; register 0 is never tracked and ignores retires/kills.
    always_comb begin
        logic [SumW-1:0] upd;
        underflow   = 1'b0;
        pendingD    = '0;
        cntD[0]     = '0;
        upd         = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            upd = updCount(cntQ[r],
                           issue_fire && issue_wr && (issue_dst == IdW'(r)),
                           wb_valid && (wb_dst == IdW'(r)),
                           kill_valid && (kill_dst == IdW'(r)));
            cntD[r]     = upd[CNT_W-1:0];
            pendingD[r] = (upd[CNT_W-1:0] != '0);
            underflow   = underflow | upd[SumW-1];
        end
    end

    // Counter state, pending mirror and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cntQ[r] <= '0;
            end
            pending <= '0;
            err     <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cntQ[r] <= cntD[r];
            end
            pending <= pendingD;
            err     <= err | underflow;
        end
    end

endmodule
